// File: rtl/ready_request_tracker_pkg.sv
// rtl/ready_request_tracker_pkg.sv - default sizing and register width helpers for the ready tracker
package ready_tracker_pkg;

  localparam int N_DEF          = 8;
  localparam int MAX_PEND_DEF   = 3;
  localparam int URGENT_AGE_DEF = 4;

  function automatic int cnt_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

  function automatic int age_w(input int urgent_age);
    return $clog2(urgent_age + 1);
  endfunction

endpackage

// File: rtl/ready_request_tracker_if.sv
// rtl/ready_request_tracker_if.sv - ready/grant handshake between tracker and priority selector
interface ready_request_tracker_if #(
  parameter int N = 8
);
  logic [N-1:0] ready;
  logic [N-1:0] ready_urgent;
  logic [N-1:0] sel;
  logic         sel_valid;
  logic         sel_valid_urgent;

  modport master (
    output ready, ready_urgent,
    input  sel, sel_valid, sel_valid_urgent
  );

  modport slave (
    input  ready, ready_urgent,
    output sel, sel_valid, sel_valid_urgent
  );
endinterface

// File: rtl/ready_request_tracker_lane.sv
// rtl/ready_request_tracker_lane.sv - one lane: pending count, wait age and sticky overflow
module ready_lane_tracker
  import ready_tracker_pkg::*;
#(
  parameter int MAX_PEND   = MAX_PEND_DEF,
  parameter int URGENT_AGE = URGENT_AGE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic grant,
  input  logic clr_err,
  output logic ready,
  output logic ready_urgent,
  output logic overflow
);
  localparam int CW = cnt_w(MAX_PEND);
  localparam int AW = age_w(URGENT_AGE);
  localparam logic [CW-1:0] CMAX = CW'(MAX_PEND);
  localparam logic [AW-1:0] AMAX = AW'(URGENT_AGE);

  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] age, age_nxt;
  logic          drop;

  always_comb begin
    count_nxt = count;
    drop      = 1'b0;
    if (req && !grant) begin
      if (count == CMAX) drop = 1'b1;
      else               count_nxt = count + 1'b1;
    end else if (grant && !req) begin
      count_nxt = count - 1'b1;
    end

    // A lane only ages across edges where it was already waiting.
    age_nxt = age;
    if (count_nxt == '0 || grant) age_nxt = '0;
    else if (ready && age != AMAX) age_nxt = age + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      age      <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      age      <= age_nxt;
      overflow <= drop | (overflow & ~clr_err);
    end
  end

  assign ready        = (count != '0);
  assign ready_urgent = ready && (age == AMAX);
endmodule

// File: rtl/ready_request_tracker.sv
// rtl/ready_request_tracker.sv - per-lane request tracker feeding the urgent/normal priority selector
module ready_request_tracker
  import ready_tracker_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int MAX_PEND   = MAX_PEND_DEF,
  parameter int URGENT_AGE = URGENT_AGE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             req,
  input  logic                     clr_err,
  ready_request_tracker_if.master  sel_if,
  output logic [N-1:0]             overflow,
  output logic                     grant_err,
  output logic                     pending_any
);
  logic [N-1:0] ready_w, urgent_w, lane_grant;
  logic         grant_vld, one_hot, hit_ready, hit_urgent, legal, illegal;

  assign grant_vld  = sel_if.sel_valid | sel_if.sel_valid_urgent;
  assign one_hot    = (sel_if.sel != '0) && ((sel_if.sel & (sel_if.sel - 1'b1)) == '0);
  assign hit_ready  = |(sel_if.sel & ready_w);
  assign hit_urgent = |(sel_if.sel & urgent_w);
  assign legal      = grant_vld && one_hot && hit_ready && (!sel_if.sel_valid_urgent || hit_urgent);
  assign illegal    = grant_vld && !legal;
  assign lane_grant = legal ? sel_if.sel : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    ready_lane_tracker #(
      .MAX_PEND  (MAX_PEND),
      .URGENT_AGE(URGENT_AGE)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req[i]),
      .grant       (lane_grant[i]),
      .clr_err     (clr_err),
      .ready       (ready_w[i]),
      .ready_urgent(urgent_w[i]),
      .overflow    (overflow[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_err <= 1'b0;
    else        grant_err <= illegal | (grant_err & ~clr_err);
  end

  assign sel_if.ready        = ready_w;
  assign sel_if.ready_urgent = urgent_w;
  assign pending_any         = |ready_w;
endmodule

// File: tb/tb_ready_request_tracker.sv
// tb/tb_ready_request_tracker.sv - directed bench with a per-lane count/age model for ready_request_tracker
module tb_ready_request_tracker;
  localparam int N  = 8;
  localparam int MP = 3;
  localparam int UA = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '1;
  logic         clr_err = 1'b0;
  logic [N-1:0] overflow;
  logic         grant_err, pending_any;

  ready_request_tracker_if #(.N(N)) bus ();

  ready_request_tracker #(.N(N), .MAX_PEND(MP), .URGENT_AGE(UA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .clr_err    (clr_err),
    .sel_if     (bus),
    .overflow   (overflow),
    .grant_err  (grant_err),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int       m_cnt [N];
  int       m_age [N];
  bit [N-1:0] m_ovf;
  bit         m_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: the specification's count/age rules applied per lane per clock edge.
  always @(posedge clk or negedge rst_n) begin : model
    bit vld, legal, g, r;
    int lane, was;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_age[i] = 0;
      end
      m_ovf = '0;
      m_err = 1'b0;
    end else begin
      vld   = bus.sel_valid || bus.sel_valid_urgent;
      legal = vld && ($countones(bus.sel) == 1);
      lane  = 0;
      for (int i = 0; i < N; i++) if (bus.sel[i]) lane = i;
      if (legal) legal = (m_cnt[lane] > 0) && (!bus.sel_valid_urgent || m_age[lane] == UA);
      m_err = (vld && !legal) || (m_err && !clr_err);
      for (int i = 0; i < N; i++) begin
        g   = legal && (lane == i);
        r   = req[i];
        was = m_cnt[i];
        if (!clr_err) ; else m_ovf[i] = 1'b0;
        if (r && !g) begin
          if (m_cnt[i] < MP) m_cnt[i]++;
          else m_ovf[i] = 1'b1;
        end else if (g && !r) begin
          m_cnt[i]--;
        end
        if (m_cnt[i] == 0 || g) m_age[i] = 0;
        else if (was > 0 && m_age[i] < UA) m_age[i]++;
      end
    end
  end

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_urgent();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cnt[i] > 0) && (m_age[i] == UA);
    return v;
  endfunction

  always @(negedge clk) begin
    check("ready", bus.ready, exp_ready());
    check("ready_urgent", bus.ready_urgent, exp_urgent());
    check("overflow", overflow, m_ovf);
    check("grant_err", grant_err, m_err);
    check("pending_any", pending_any, |exp_ready());
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] s,
                     input logic v, input logic u, input logic c);
    req = r; bus.sel = s; bus.sel_valid = v; bus.sel_valid_urgent = u; clr_err = c;
    @(negedge clk);
    req = '0; bus.sel = '0; bus.sel_valid = 1'b0; bus.sel_valid_urgent = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    bus.sel = '0; bus.sel_valid = 1'b0; bus.sel_valid_urgent = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 8'h00);
    check("rst_ovf", overflow, 8'h00);
    check("rst_pend", pending_any, 1'b0);
    req = '0;
    rst_n = 1'b1;
    cyc(8'h00, 8'h00, 0, 0, 0);
    check("post_rst_ready", bus.ready, 8'h00);

    cyc(8'h01, 8'h00, 0, 0, 0);
    check("single_ready", bus.ready, 8'h01);
    check("single_not_urg", bus.ready_urgent, 8'h00);
    repeat (3) cyc(8'h00, 8'h00, 0, 0, 0);
    check("single_urg_early", bus.ready_urgent, 8'h00);
    cyc(8'h00, 8'h00, 0, 0, 0);
    check("single_urg", bus.ready_urgent, 8'h01);
    cyc(8'h00, 8'h01, 0, 1, 0);
    check("urg_grant_ready", bus.ready, 8'h00);
    check("urg_grant_urg", bus.ready_urgent, 8'h00);
    check("urg_grant_err", grant_err, 1'b0);

    repeat (3) cyc(8'h04, 8'h00, 0, 0, 0);
    check("sat_no_ovf", overflow, 8'h00);
    cyc(8'h04, 8'h00, 0, 0, 0);
    check("sat_ovf", overflow, 8'h04);
    check("model_cnt2", m_cnt[2], 3);
    repeat (2) cyc(8'h00, 8'h04, 1, 0, 0);
    check("sat_still_ready", bus.ready, 8'h04);
    cyc(8'h00, 8'h04, 1, 0, 0);
    check("sat_drained", bus.ready, 8'h00);
    cyc(8'h00, 8'h00, 0, 0, 1);
    check("sat_clr", overflow, 8'h00);

    cyc(8'h08, 8'h00, 0, 0, 0);
    cyc(8'h08, 8'h08, 1, 0, 0);
    check("simul_ready", bus.ready, 8'h08);
    check("simul_ovf", overflow, 8'h00);
    check("model_cnt3", m_cnt[3], 1);
    check("model_age3", m_age[3], 0);
    cyc(8'h00, 8'h08, 1, 0, 0);
    check("simul_drain", bus.ready, 8'h00);

    cyc(8'h30, 8'h00, 0, 0, 0);
    cyc(8'h00, 8'h30, 1, 0, 0);
    check("ill_multi_err", grant_err, 1'b1);
    check("ill_multi_ready", bus.ready, 8'h30);
    cyc(8'h00, 8'h40, 1, 0, 1);
    check("ill_empty_err_wins", grant_err, 1'b1);
    cyc(8'h00, 8'h00, 0, 0, 1);
    check("err_clr", grant_err, 1'b0);
    cyc(8'h00, 8'h10, 0, 1, 0);
    check("ill_urg_err", grant_err, 1'b1);
    check("ill_urg_cnt4", m_cnt[4], 1);
    check("now_urgent", bus.ready_urgent, 8'h30);
    cyc(8'h00, 8'h10, 0, 1, 0);
    check("urg_legal_ready", bus.ready, 8'h20);
    cyc(8'h00, 8'h20, 1, 0, 1);
    check("drain_clr_ready", bus.ready, 8'h00);
    check("drain_clr_err", grant_err, 1'b0);
    cyc(8'h00, 8'hFF, 0, 0, 0);
    check("novld_ignored", grant_err, 1'b0);

    cyc(8'h38, 8'h00, 0, 0, 0);
    cyc(8'h00, 8'h00, 0, 0, 0);
    cyc(8'h00, 8'h08, 1, 0, 0);
    cyc(8'h00, 8'h00, 0, 0, 0);
    check("age_c3_urg", bus.ready_urgent, 8'h00);
    cyc(8'h00, 8'h00, 0, 0, 0);
    check("age_c4_urg", bus.ready_urgent, 8'h30);
    check("age_c4_ready", bus.ready, 8'h30);

    repeat (4) cyc(8'h01, 8'h00, 0, 0, 0);
    check("pre_rst_ovf", overflow, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", bus.ready, 8'h00);
    check("async_rst_ovf", overflow, 8'h00);
    check("async_rst_pend", pending_any, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_ready", bus.ready, 8'h00);
    cyc(8'h00, 8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
